// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port: ALU (A)
// and memory (M) producers, round-robin on conflict, plus a RAW scoreboard.
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int CNT_W      = 2,
    parameter bit R0_PROTECT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              AValid,
    output logic              AReady,
    input  logic [ADDR_W-1:0] AAddr,
    input  logic [DATA_W-1:0] AData,
    input  logic              MValid,
    output logic              MReady,
    input  logic [ADDR_W-1:0] MAddr,
    input  logic [DATA_W-1:0] MData,
    input  logic              IssueValid,
    input  logic [ADDR_W-1:0] IssueDest,
    output logic              IssueReady,
    input  logic              Flush,
    input  logic [ADDR_W-1:0] Readregister1,
    input  logic [ADDR_W-1:0] Readregister2,
    output logic              Busy1,
    output logic              Busy2,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] Writeregister,
    output logic [DATA_W-1:0] Writedata,
    output logic              Underflow
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        PREF_M = 1'b0,
        PREF_A = 1'b1
    } pref_t;

    pref_t pref_q;
    pref_t pref_d;

    logic              hold;
    logic              grant_a;
    logic              grant_m;
    logic              xfer;
    logic              xfer_tracked;
    logic              drive;
    logic [ADDR_W-1:0] xfer_addr;
    logic [DATA_W-1:0] xfer_data;

    logic [CNT_W-1:0]  cnt [NREG];
    logic [NREG-1:0]   inc_vec;
    logic [NREG-1:0]   dec_vec;
    logic              issue_ok;
    logic              underflow_set;

    assign hold = rst | Flush;

    // Round-robin pointer only moves when both producers compete.
    always_comb begin
        grant_a = 1'b0;
        grant_m = 1'b0;
        pref_d  = pref_q;
        if (!hold) begin
            if (AValid && MValid) begin
                if (pref_q == PREF_M) begin
                    grant_m = 1'b1;
                    pref_d  = PREF_A;
                end else begin
                    grant_a = 1'b1;
                    pref_d  = PREF_M;
                end
            end else begin
                grant_a = AValid;
                grant_m = MValid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pref_q <= PREF_M;
        end else begin
            pref_q <= pref_d;
        end
    end

    assign AReady = grant_a;
    assign MReady = grant_m;

    assign xfer      = grant_a | grant_m;
    assign xfer_addr = grant_a ? AAddr : MAddr;
    assign xfer_data = grant_a ? AData : MData;

    assign xfer_tracked = xfer && (xfer_addr != '0);
    assign drive = xfer && !(R0_PROTECT && (xfer_addr == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite      <= 1'b0;
            Writeregister <= '0;
            Writedata     <= '0;
        end else begin
            RegWrite <= drive;
            if (drive) begin
                Writeregister <= xfer_addr;
                Writedata     <= xfer_data;
            end
        end
    end

    // A transfer retiring the same register frees the slot being issued.
    assign IssueReady = (IssueDest == '0)
                     || (cnt[IssueDest] != CNT_MAX)
                     || (xfer && (xfer_addr == IssueDest));

    assign issue_ok = IssueValid && IssueReady
                   && (IssueDest != '0) && !hold;

    assign inc_vec = issue_ok ? (NREG'(1) << IssueDest) : '0;
    assign dec_vec = xfer_tracked ? (NREG'(1) << xfer_addr) : '0;

    assign underflow_set = xfer_tracked
                        && (cnt[xfer_addr] == '0)
                        && !inc_vec[xfer_addr];

    always_ff @(posedge clk) begin
        if (rst || Flush) begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                case ({inc_vec[i], dec_vec[i]})
                    2'b10: cnt[i] <= cnt[i] + CNT_W'(1);
                    2'b01: begin
                        if (cnt[i] != '0) begin
                            cnt[i] <= cnt[i] - CNT_W'(1);
                        end
                    end
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Underflow <= 1'b0;
        end else if (underflow_set) begin
            Underflow <= 1'b1;
        end
    end

    assign Busy1 = (Readregister1 != '0) && (cnt[Readregister1] != '0);
    assign Busy2 = (Readregister2 != '0) && (cnt[Readregister2] != '0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a cycle model predicts handshakes
// and scoreboard state; a monitor matches register-file writes in order.
module tb_regfile_wb_arbiter;

    localparam int CMAX = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        AValid, MValid, IssueValid, Flush;
    logic        AReady, MReady, IssueReady;
    logic [4:0]  AAddr, MAddr, IssueDest;
    logic [31:0] AData, MData;
    logic [4:0]  Readregister1, Readregister2;
    logic        Busy1, Busy2, RegWrite, Underflow;
    logic [4:0]  Writeregister;
    logic [31:0] Writedata;

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .AValid(AValid), .AReady(AReady), .AAddr(AAddr), .AData(AData),
        .MValid(MValid), .MReady(MReady), .MAddr(MAddr), .MData(MData),
        .IssueValid(IssueValid), .IssueDest(IssueDest),
        .IssueReady(IssueReady), .Flush(Flush),
        .Readregister1(Readregister1), .Readregister2(Readregister2),
        .Busy1(Busy1), .Busy2(Busy2), .RegWrite(RegWrite),
        .Writeregister(Writeregister), .Writedata(Writedata),
        .Underflow(Underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];

    int cnt[32];
    bit pref_m = 1'b1;
    bit und = 1'b0;
    bit a_acc = 1'b0;
    bit m_acc = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: evaluated mid-cycle with inputs stable.
    always @(negedge clk) begin
        bit ea, em, xf, eir;
        logic [4:0] xa;
        logic [31:0] xd;
        int ir;
        ea = 1'b0;
        em = 1'b0;
        if (!rst && !Flush) begin
            if (AValid && MValid) begin
                if (pref_m) em = 1'b1;
                else ea = 1'b1;
            end else begin
                ea = AValid;
                em = MValid;
            end
        end
        chk("a_ready", AReady, ea);
        chk("m_ready", MReady, em);
        a_acc = ea;
        m_acc = em;
        if (rst) begin
            foreach (cnt[i]) cnt[i] = 0;
            pref_m = 1'b1;
            und = 1'b0;
        end else begin
            xf = ea || em;
            xa = ea ? AAddr : MAddr;
            xd = ea ? AData : MData;
            eir = (IssueDest == 0) || (cnt[IssueDest] < CMAX)
               || (xf && xa == IssueDest);
            chk("issue_ready", IssueReady, eir);
            chk("busy1", Busy1,
                Readregister1 != 0 && cnt[Readregister1] != 0);
            chk("busy2", Busy2,
                Readregister2 != 0 && cnt[Readregister2] != 0);
            chk("underflow", Underflow, und);
            if (xf && xa != 0) exp_q.push_back('{a: xa, d: xd});
            if (Flush) begin
                foreach (cnt[i]) cnt[i] = 0;
            end else begin
                ir = (IssueValid && eir) ? int'(IssueDest) : 0;
                if (ir != 0) cnt[ir]++;
                if (xf && xa != 0) begin
                    if (ir == int'(xa)) cnt[xa]--;
                    else if (cnt[xa] == 0) und = 1'b1;
                    else cnt[xa]--;
                end
                if (AValid && MValid) pref_m = !pref_m;
            end
        end
    end

    // Monitor: every register-file write must match the oldest transfer.
    always begin
        wr_t w;
        @(posedge clk);
        #2;
        if (RegWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                w = exp_q.pop_front();
                chk("wr_addr", Writeregister, w.a);
                chk("wr_data", Writedata, w.d);
            end
        end else if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            chk("missing_write", RegWrite, 1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        AValid = 0; AAddr = 0; AData = 0;
        MValid = 0; MAddr = 0; MData = 0;
        IssueValid = 0; IssueDest = 0; Flush = 0;
        Readregister1 = 0; Readregister2 = 0;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1;
        step();
        step();
        rst = 0;
        chk("rst_regwrite", RegWrite, 0);
        chk("rst_wreg", Writeregister, 0);
        chk("rst_wdata", Writedata, 0);
        chk("rst_underflow", Underflow, 0);
    endtask

    initial begin
        clear_in();
        rst = 1;
        do_reset();

        // single ALU write-back
        AValid = 1; AAddr = 5; AData = 32'h1234;
        step();
        clear_in();
        step();
        step();

        // sustained conflict alternates M,A,M,A
        AValid = 1; AAddr = 3; AData = 32'hA3;
        MValid = 1; MAddr = 4; MData = 32'hB4;
        repeat (4) step();
        clear_in();
        step();

        // two pending writes to r7
        do_reset();
        Readregister1 = 7;
        IssueValid = 1; IssueDest = 7;
        step();
        step();
        IssueValid = 0;
        step();
        AValid = 1; AAddr = 7; AData = 32'h77;
        step();
        AData = 32'h78;
        step();
        AValid = 0;
        step();
        step();

        // saturation at r9 and same-cycle release
        do_reset();
        Readregister2 = 9;
        IssueValid = 1; IssueDest = 9;
        repeat (3) step();
        step();
        AValid = 1; AAddr = 9; AData = 32'h99;
        step();
        AValid = 0; IssueValid = 0;
        step();
        step();

        // r0 write dropped, underflow on r2
        do_reset();
        AValid = 1; AAddr = 0; AData = 32'hFFFF;
        step();
        AValid = 0;
        step();
        MValid = 1; MAddr = 2; MData = 32'h22;
        step();
        MValid = 0;
        step();
        step();

        // flush blocks the memory port for one cycle
        do_reset();
        Readregister2 = 6;
        IssueValid = 1; IssueDest = 6;
        step();
        Flush = 1;
        MValid = 1; MAddr = 8; MData = 32'h88;
        step();
        Flush = 0; IssueValid = 0;
        step();
        MValid = 0;
        step();
        step();

        // randomized traffic with held requests
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if (!(AValid && !a_acc)) begin
                AValid = ($urandom % 3) != 0;
                AAddr = 5'($urandom % 12);
                AData = $urandom;
            end
            if (!(MValid && !m_acc)) begin
                MValid = ($urandom % 3) != 0;
                MAddr = 5'($urandom % 12);
                MData = $urandom;
            end
            Flush = ($urandom % 25) == 0;
            IssueValid = $urandom % 2;
            IssueDest = 5'($urandom % 12);
            Readregister1 = 5'($urandom % 12);
            Readregister2 = 5'($urandom % 12);
            step();
        end
        clear_in();
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
